// File: rtl/sram_grid_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_grid_ctrl
// Brief   : Two-port round-robin sequencer for an 8x8 SRAM grid (rw/wordLine).
// Revision: 1.0 - initial release
// ============================================================================
module sram_grid_ctrl #(
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDR_W-1:0]        a_addr,
    input  logic [DATA_W-1:0]        a_wdata,
    output logic                     a_ack,
    output logic [DATA_W-1:0]        a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        b_wdata,
    output logic                     b_ack,
    output logic [DATA_W-1:0]        b_rdata,
    output logic                     mem_rw,
    output logic [(2**ADDR_W)-1:0]   mem_wordLine,
    output logic [DATA_W-1:0]        mem_i,
    input  logic [DATA_W-1:0]        mem_bitLines,
    output logic                     busy
);

    localparam int                  c_WORDS = 2**ADDR_W;
    localparam logic [3:0]          c_ACC   = 4'(ACCESS_CYCLES);
    localparam logic [c_WORDS-1:0]  c_ONE   = {{(c_WORDS-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_gnt;    // 0 = port A, 1 = port B
    logic              r_last;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic              w_gnt_valid;
    logic              w_gnt_sel;
    logic              w_active;

    // On a tie the port that was not served last wins.
    always_comb begin
        w_gnt_valid = a_req | b_req;
        if (a_req && b_req) begin
            w_gnt_sel = ~r_last;
        end else begin
            w_gnt_sel = b_req;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= 4'd0;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt   <= w_gnt_sel;
                        r_we    <= w_gnt_sel ? b_we   : a_we;
                        r_addr  <= w_gnt_sel ? b_addr : a_addr;
                        // Reads drive an all-zero data word into the array.
                        if (w_gnt_sel) begin
                            r_wdata <= b_we ? b_wdata : '0;
                        end else begin
                            r_wdata <= a_we ? a_wdata : '0;
                        end
                        r_cnt   <= c_ACC;
                        r_state <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    r_state <= c_ACCESS;
                end
                c_ACCESS: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= c_HOLD;
                        if (!r_we) begin
                            if (r_gnt) begin
                                r_b_rdata <= mem_bitLines;
                            end else begin
                                r_a_rdata <= mem_bitLines;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_HOLD: begin
                    r_last  <= r_gnt;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // rw/data stay valid from SETUP through HOLD, bracketing the wordline pulse.
    assign w_active     = (r_state != c_IDLE);
    assign mem_rw       = w_active & r_we;
    assign mem_i        = w_active ? r_wdata : '0;
    assign mem_wordLine = (r_state == c_ACCESS) ? (c_ONE << r_addr) : '0;

    assign a_ack   = (r_state == c_HOLD) & ~r_gnt;
    assign b_ack   = (r_state == c_HOLD) &  r_gnt;
    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;
    assign busy    = w_active;

endmodule
`default_nettype wire

// File: doc/sram_grid_ctrl.md
Name: sram_grid_ctrl

Overview:
Sequencing controller and two-port arbiter for the 8x8 SRAM grid array (rw / one-hot wordLine / input word / bitLinesOut interface). Two requesters (port A, port B) issue single-word read or write transactions over a req/ack handshake. The controller round-robin arbitrates and decodes the address to a one-hot wordline. It orders rw and data setup strictly around the wordline pulse so that no spurious write occurs, and captures read data from the bitlines.

Parameters:
ADDR_W, 3, word address width; the array has 2**ADDR_W words.
DATA_W, 8, word width.
ACCESS_CYCLES, 2, number of cycles the wordline is held active; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
a_req  input  1  port A request, held until a_ack
a_we  input  1  port A: 1 = write, 0 = read
a_addr  input  ADDR_W  port A word address
a_wdata  input  DATA_W  port A write data
a_ack  output  1  port A one-cycle completion pulse
a_rdata  output  DATA_W  port A read data
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
mem_rw  output  1  to array rw (1 = write)
mem_wordLine  output  2**ADDR_W  to array wordLine, one-hot or zero
mem_i  output  DATA_W  to array word input
mem_bitLines  input  DATA_W  from array bitLinesOut
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst_n low at a rising edge): state to IDLE, last-grant register to B, so A wins the first tie.
- Reset values: mem_wordLine = 0, mem_rw = 0, mem_i = 0, a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0.
- Reset mid-transaction aborts it: no ack is issued and the wordline is low from the next cycle. Array contents are not touched by the controller.
- States: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE:
  - Samples a_req and b_req. With neither asserted, it stays.
  - With one asserted, that port is granted.
  - With both asserted, the port not granted last wins (round-robin).
  - On grant, we/addr/wdata and the granted port ID are latched; transition to SETUP. Inputs are ignored after latching.
- SETUP (1 cycle): mem_rw = latched we, mem_i = latched wdata (0 for reads), mem_wordLine = 0.
- ACCESS (ACCESS_CYCLES cycles, down-counter): mem_wordLine = 1 << addr. mem_rw and mem_i are held stable.
- Read capture: on the edge leaving the last ACCESS cycle, mem_bitLines is registered into the granted port's rdata.
- HOLD (1 cycle):
  - mem_wordLine = 0; mem_rw and mem_i are still held, so rw/data never change while a wordline is high.
  - Granted port's ack = 1 for exactly this cycle. Its rdata is valid with ack and held until that port's next read completes; writes leave rdata unchanged.
  - Last-grant register updated.
  - Next state IDLE. In IDLE, mem_rw = 0 and mem_i = 0.
- Latency: req sampled in IDLE at cycle 0 -> ack in cycle 2+ACCESS_CYCLES (4 with defaults). Transaction period is 3+ACCESS_CYCLES cycles.
- Handshake:
  - A requester deasserts req in the cycle after ack.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - A requester losing arbitration keeps req high and is served next, so no starvation.
- Only one wordline bit is ever high. mem_wordLine is never nonzero outside ACCESS.
- Address wrap: none. The full address range 0..2**ADDR_W-1 is valid; no out-of-range case exists.

Test Plan:
- Port A writes 42 to addr 0, 255 to addr 1, 69 to addr 3, 127 to addr 7, then reads each back -> a_rdata = 42/255/69/127. Ack arrives 4 cycles after req. mem_wordLine = 0x01/0x02/0x08/0x80 during ACCESS only.
- A and B assert req in the same cycle (A writes 0x11 to addr 2, B writes 0x22 to addr 5) -> A is acked first, then B. Holding both reqs with new transactions -> grants alternate B, A, B.
- Monitor every cycle -> mem_rw and mem_i never change while mem_wordLine is nonzero, and mem_wordLine is at most one-hot.
- rst_n low during the second ACCESS cycle of a write of 0x5A to addr 4 -> next cycle: wordLine = 0, no ack, busy = 0. A subsequent normal read of addr 1 returns 255.
- ACCESS_CYCLES = 1: B reads addr 7 -> b_ack 3 cycles after req with b_rdata = 127. a_rdata is unchanged.
- B writes while A holds a previous read result of 69 -> a_rdata stays 69, and a_ack is never pulsed for B's transaction.
